// File: rtl/axi_lite_master_cmd_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite command master.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } axil_mst_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_DATA = 32'h0BAD_0BAD;

endpackage

// File: rtl/axi_lite_master_cmd_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_master_cmd_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master driven by a local valid/ready command channel.
// Optional handshake watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master_cmd
  import axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  axi_lite_master_cmd_if.master           m_axi
);

  axil_mst_state_t state_reg, state_next;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_reg, wstrb_next;
  logic awvalid_reg, awvalid_next;
  logic wvalid_reg, wvalid_next;
  logic bready_reg, bready_next;
  logic arvalid_reg, arvalid_next;
  logic rready_reg, rready_next;
  logic cmd_ready_reg, cmd_ready_next;
  logic rsp_valid_reg, rsp_valid_next;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0] rsp_resp_reg, rsp_resp_next;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic rsp_timeout_reg, rsp_timeout_next;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt_reg         <= '0;
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt_reg         <= cnt_next;
      rsp_timeout_reg <= rsp_timeout_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
`ifdef AXIL_MASTER_TIMEOUT_EN
    cnt_next         = '0;
    rsp_timeout_next = rsp_timeout_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          wstrb_next = cmd_wstrb;
`ifdef AXIL_MASTER_TIMEOUT_EN
          rsp_timeout_next = 1'b0;
`endif
          if (cmd_write) begin
            state_next   = WR_AW_W;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = RD_AR;
            arvalid_next = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W retire independently; B is only opened once both are gone.
        if (awvalid_reg && m_axi.awready) awvalid_next = 1'b0;
        if (wvalid_reg && m_axi.wready)   wvalid_next  = 1'b0;
        if (!awvalid_next && !wvalid_next) begin
          state_next  = WR_B;
          bready_next = 1'b1;
        end
      end
      WR_B: begin
        if (m_axi.bvalid && bready_reg) begin
          bready_next    = 1'b0;
          rsp_resp_next  = m_axi.bresp;
          rsp_rdata_next = '0;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end
      RD_AR: begin
        if (arvalid_reg && m_axi.arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_R;
        end
      end
      RD_R: begin
        if (m_axi.rvalid && rready_reg) begin
          rready_next    = 1'b0;
          rsp_resp_next  = m_axi.rresp;
          rsp_rdata_next = m_axi.rdata;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Counter restarts on every state entry, so each wait phase gets the full budget.
    if ((state_reg inside {WR_AW_W, WR_B, RD_AR, RD_R}) && (state_next == state_reg)) begin
      if (cnt_reg == CNT_MAX) begin
        awvalid_next     = 1'b0;
        wvalid_next      = 1'b0;
        bready_next      = 1'b0;
        arvalid_next     = 1'b0;
        rready_next      = 1'b0;
        rsp_valid_next   = 1'b1;
        rsp_resp_next    = RESP_SLVERR;
        rsp_rdata_next   = C_M_AXI_DATA_WIDTH'(TIMEOUT_DATA);
        rsp_timeout_next = 1'b1;
        state_next       = RSP;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
`endif

    cmd_ready_next = (state_next == IDLE);
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
`ifdef AXIL_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_reg;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign m_axi.awaddr  = addr_reg;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_reg;
  assign m_axi.wdata   = wdata_reg;
  assign m_axi.wstrb   = wstrb_reg;
  assign m_axi.wvalid  = wvalid_reg;
  assign m_axi.bready  = bready_reg;
  assign m_axi.araddr  = addr_reg;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_reg;
  assign m_axi.rready  = rready_reg;

endmodule
